// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared fetch-stage state codes and constants
package if_fetch_stage_pkg;
    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,
        IF_HOLD  = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] PC_INC    = 32'd4;
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction
endpackage

// File: rtl/if_fetch_stage_pc_reg.sv
// if_pc_reg: program counter with async reset, load and +4 increment (load wins)
module if_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_inc,
    input  logic [31:0] i_load_val,
    output logic [31:0] o_pc
);
    import if_fetch_stage_pkg::*;
    logic [31:0] r_pc;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_pc <= RESET_PC;
        else if (i_load)
            r_pc <= i_load_val;
        else if (i_inc)
            r_pc <= r_pc + PC_INC;
    assign o_pc = r_pc;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC ownership, imem req/ack handshake, freeze hold and branch redirect drain
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction,
    output logic        valid,
    output logic        fetch_stall
);
    import if_fetch_stage_pkg::*;
    if_state_t   r_state, w_next;
    logic [31:0] r_redirect, r_hold_instr, r_hold_pc;
    logic [31:0] w_pc, w_pc4, w_baddr, w_load_val, w_instr, w_pc_out;
    logic        w_load, w_inc, w_req, w_valid, w_hold_en, w_redir_en;

    assign w_pc4   = w_pc + PC_INC;
    assign w_baddr = word_align(branch_addr);

    if_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_inc      (w_inc),
        .i_load_val (w_load_val),
        .o_pc       (w_pc)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state      <= IF_FETCH;
            r_redirect   <= '0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
        end else begin
            r_state <= w_next;
            if (w_redir_en)
                r_redirect <= w_baddr;
            if (w_hold_en) begin
                r_hold_instr <= imem_rdata;
                r_hold_pc    <= w_pc4;
            end
        end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = w_baddr;
        w_inc      = 1'b0;
        w_req      = 1'b0;
        w_valid    = 1'b0;
        w_instr    = NOP_INSTR;
        w_pc_out   = '0;
        w_hold_en  = 1'b0;
        w_redir_en = 1'b0;
        case (r_state)
            IF_FETCH: begin
                w_req    = 1'b1;
                w_valid  = imem_ack & ~branch_taken;
                w_instr  = w_valid ? imem_rdata : NOP_INSTR;
                w_pc_out = w_valid ? w_pc4 : '0;
                if (branch_taken & imem_ack)
                    w_load = 1'b1;
                else if (branch_taken) begin
                    w_redir_en = 1'b1;
                    w_next     = IF_DRAIN;
                end else if (imem_ack & ~freeze)
                    w_inc = 1'b1;
                else if (imem_ack) begin
                    w_hold_en = 1'b1;
                    w_next    = IF_HOLD;
                end
            end
            IF_HOLD: begin
                w_valid  = 1'b1;
                w_instr  = r_hold_instr;
                w_pc_out = r_hold_pc;
                if (branch_taken) begin
                    w_load = 1'b1;
                    w_next = IF_FETCH;
                end else if (~freeze) begin
                    w_inc  = 1'b1;
                    w_next = IF_FETCH;
                end
            end
            IF_DRAIN: begin
                // the outstanding read must complete before the redirect target is fetched
                w_req      = 1'b1;
                w_redir_en = branch_taken;
                w_load_val = branch_taken ? w_baddr : r_redirect;
                w_load     = imem_ack;
                w_next     = imem_ack ? IF_FETCH : IF_DRAIN;
            end
            default: w_next = IF_FETCH;
        endcase
    end

    assign imem_req    = ~rst & w_req;
    assign imem_addr   = rst ? RESET_PC : w_pc;
    assign valid       = ~rst & w_valid;
    assign instruction = rst ? NOP_INSTR : w_instr;
    assign pc_out      = rst ? 32'h0 : w_pc_out;
    assign fetch_stall = ~rst & ~w_valid;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed scenarios plus randomized run against a behavioural fetch model
module tb_if_fetch_stage;
    logic        clk, rst, freeze, branch_taken, imem_ack, imem_req, valid, fetch_stall;
    logic [31:0] branch_addr, imem_rdata, imem_addr, pc_out, instruction;
    int          n_cmp, n_bad;

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_out(pc_out),
        .instruction(instruction), .valid(valid), .fetch_stall(fetch_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic drive(input logic f, input logic b, input logic [31:0] ba,
                         input logic a, input logic [31:0] rd);
        freeze = f; branch_taken = b; branch_addr = ba; imem_ack = a; imem_rdata = rd;
        #1;
    endtask

    task automatic adv;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; imem_ack = 1'b0; imem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(0, 0, 32'h0, 1, 32'hDEAD_BEEF);
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", valid); end
        n_cmp++; if (instruction !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", instruction); end
        n_cmp++; if (pc_out !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", pc_out); end
        n_cmp++; if (fetch_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", fetch_stall); end
        adv;
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 32'h0);
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rst_first_req: got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_first_addr: got %h want 0", imem_addr); end
        n_cmp++; if (fetch_stall !== 1'b1) begin n_bad++; $display("FAIL rst_first_stall: got %b want 1", fetch_stall); end
        adv;
    endtask

    task automatic test_zero_wait;
        do_reset;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 32'h0, 1, memf(32'(4 * i)));
            n_cmp++; if (imem_addr !== 32'(4 * i)) begin n_bad++; $display("FAIL zw_addr[%0d]: got %h want %h", i, imem_addr, 32'(4 * i)); end
            n_cmp++; if (pc_out !== 32'(4 * i + 4)) begin n_bad++; $display("FAIL zw_pc[%0d]: got %h want %h", i, pc_out, 32'(4 * i + 4)); end
            n_cmp++; if (instruction !== memf(32'(4 * i))) begin n_bad++; $display("FAIL zw_instr[%0d]: got %h want %h", i, instruction, memf(32'(4 * i))); end
            n_cmp++; if (valid !== 1'b1 || fetch_stall !== 1'b0) begin n_bad++; $display("FAIL zw_vs[%0d]: got %b%b want 10", i, valid, fetch_stall); end
            adv;
        end
    endtask

    task automatic test_wait_states;
        do_reset;
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 32'h0, 0, 32'h0);
            n_cmp++; if (fetch_stall !== 1'b1 || valid !== 1'b0) begin n_bad++; $display("FAIL ws_stall[%0d]: got %b%b want 10", i, fetch_stall, valid); end
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL ws_req[%0d]: got %b %h want 1 0", i, imem_req, imem_addr); end
            adv;
        end
        drive(0, 0, 32'h0, 1, 32'hE3A0_1001);
        n_cmp++; if (valid !== 1'b1 || fetch_stall !== 1'b0) begin n_bad++; $display("FAIL ws_valid: got %b%b want 10", valid, fetch_stall); end
        n_cmp++; if (pc_out !== 32'h4) begin n_bad++; $display("FAIL ws_pc: got %h want 4", pc_out); end
        n_cmp++; if (instruction !== 32'hE3A0_1001) begin n_bad++; $display("FAIL ws_instr: got %h want e3a01001", instruction); end
        adv;
        drive(0, 0, 32'h0, 0, 32'h0);
        n_cmp++; if (valid !== 1'b0 || imem_addr !== 32'h4) begin n_bad++; $display("FAIL ws_next: got %b %h want 0 4", valid, imem_addr); end
        adv;
    endtask

    task automatic test_freeze_hold;
        do_reset;
        drive(1, 0, 32'h0, 1, 32'h1234_5678);
        n_cmp++; if (valid !== 1'b1 || pc_out !== 32'h4) begin n_bad++; $display("FAIL fh_first: got %b %h want 1 4", valid, pc_out); end
        adv;
        for (int i = 0; i < 3; i++) begin
            drive(i < 2, 0, 32'h0, 1, 32'hFFFF_0000);
            n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL fh_req[%0d]: got %b want 0", i, imem_req); end
            n_cmp++; if (valid !== 1'b1 || fetch_stall !== 1'b0) begin n_bad++; $display("FAIL fh_vs[%0d]: got %b%b want 10", i, valid, fetch_stall); end
            n_cmp++; if (instruction !== 32'h1234_5678) begin n_bad++; $display("FAIL fh_instr[%0d]: got %h want 12345678", i, instruction); end
            n_cmp++; if (pc_out !== 32'h4) begin n_bad++; $display("FAIL fh_pc[%0d]: got %h want 4", i, pc_out); end
            adv;
        end
        drive(0, 0, 32'h0, 0, 32'h0);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_bad++; $display("FAIL fh_next: got %b %h want 1 4", imem_req, imem_addr); end
        adv;
    endtask

    task automatic test_branch_drain;
        do_reset;
        drive(0, 0, 32'h0, 1, 32'h0); adv;
        drive(0, 0, 32'h0, 1, 32'h0); adv;
        drive(0, 1, 32'h100, 0, 32'h0);
        n_cmp++; if (imem_addr !== 32'h8 || fetch_stall !== 1'b1) begin n_bad++; $display("FAIL bd_issue: got %h %b want 8 1", imem_addr, fetch_stall); end
        adv;
        drive(0, 0, 32'h0, 0, 32'h0);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_bad++; $display("FAIL bd_wait: got %b %h want 1 8", imem_req, imem_addr); end
        adv;
        drive(0, 0, 32'h0, 1, 32'hBAD0_BAD0);
        n_cmp++; if (imem_addr !== 32'h8) begin n_bad++; $display("FAIL bd_ack_addr: got %h want 8", imem_addr); end
        n_cmp++; if (valid !== 1'b0 || instruction !== 32'h0 || pc_out !== 32'h0) begin n_bad++; $display("FAIL bd_drop: got %b %h %h want 0 0 0", valid, instruction, pc_out); end
        adv;
        drive(0, 0, 32'h0, 0, 32'h0);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_bad++; $display("FAIL bd_target: got %b %h want 1 100", imem_req, imem_addr); end
        adv;
    endtask

    task automatic test_branch_same_cycle;
        do_reset;
        drive(0, 1, 32'h203, 1, 32'h0);
        n_cmp++; if (valid !== 1'b0 || fetch_stall !== 1'b1) begin n_bad++; $display("FAIL bs_drop: got %b%b want 01", valid, fetch_stall); end
        adv;
        drive(0, 0, 32'h0, 0, 32'h0);
        n_cmp++; if (imem_addr !== 32'h200) begin n_bad++; $display("FAIL bs_addr: got %h want 200", imem_addr); end
        adv;
        drive(0, 1, 32'hFFFF_FFFF, 1, 32'h0); adv;
        drive(0, 0, 32'h0, 1, 32'hCAFE_F00D);
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
        n_cmp++; if (valid !== 1'b1 || pc_out !== 32'h0) begin n_bad++; $display("FAIL wrap_pc: got %b %h want 1 0", valid, pc_out); end
        adv;
        drive(0, 0, 32'h0, 0, 32'h0);
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_next: got %h want 0", imem_addr); end
        adv;
    endtask

    task automatic test_reset_mid_read;
        do_reset;
        drive(0, 0, 32'h0, 1, 32'h0); adv;
        drive(0, 0, 32'h0, 1, 32'h0); adv;
        drive(0, 0, 32'h0, 0, 32'h0); adv;
        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 32'h0);
        n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL rm_abandon: got %b %h want 0 0", imem_req, imem_addr); end
        adv;
        drive(0, 0, 32'h0, 1, 32'h7777_7777);
        n_cmp++; if (valid !== 1'b0 || instruction !== 32'h0 || pc_out !== 32'h0 || fetch_stall !== 1'b0) begin n_bad++; $display("FAIL rm_late_ack: got %b %h %h %b want 0 0 0 0", valid, instruction, pc_out, fetch_stall); end
        adv;
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 32'h0);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL rm_restart: got %b %h want 1 0", imem_req, imem_addr); end
        adv;
        drive(0, 0, 32'h0, 1, 32'h1111_2222);
        n_cmp++; if (valid !== 1'b1 || pc_out !== 32'h4) begin n_bad++; $display("FAIL rm_first: got %b %h want 1 4", valid, pc_out); end
        adv;
    endtask

    task automatic test_random;
        logic [31:0] m_pc, m_red, m_hi, m_hp, ba, e_instr, e_pc;
        logic        m_hold, m_drain, f, b, a, e_req, e_valid;
        do_reset;
        m_pc = 32'h0; m_red = '0; m_hi = '0; m_hp = '0; m_hold = 1'b0; m_drain = 1'b0;
        for (int i = 0; i < 600; i++) begin
            f  = ($urandom_range(0, 99) < 30);
            b  = ($urandom_range(0, 99) < 12);
            a  = 1'($urandom_range(0, 1));
            ba = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            e_req   = !m_hold;
            e_valid = m_hold || (a && !b && !m_drain);
            e_instr = m_hold ? m_hi : (e_valid ? memf(m_pc) : 32'h0);
            e_pc    = m_hold ? m_hp : (e_valid ? m_pc + 32'd4 : 32'h0);
            drive(f, b, ba, a, memf(m_pc));
            n_cmp++; if (imem_req !== e_req) begin n_bad++; $display("FAIL rnd_req[%0d]: got %b want %b", i, imem_req, e_req); end
            if (e_req) begin
                n_cmp++; if (imem_addr !== m_pc) begin n_bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, imem_addr, m_pc); end
            end
            n_cmp++; if (valid !== e_valid || fetch_stall !== !e_valid) begin n_bad++; $display("FAIL rnd_vs[%0d]: got %b%b want %b%b", i, valid, fetch_stall, e_valid, !e_valid); end
            n_cmp++; if (instruction !== e_instr) begin n_bad++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, instruction, e_instr); end
            n_cmp++; if (pc_out !== e_pc) begin n_bad++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc_out, e_pc); end
            adv;
            if (m_hold) begin
                if (b) begin m_pc = ba & ~32'h3; m_hold = 1'b0; end
                else if (!f) begin m_pc = m_pc + 32'd4; m_hold = 1'b0; end
            end else if (m_drain) begin
                if (b) m_red = ba & ~32'h3;
                if (a) begin m_pc = m_red; m_drain = 1'b0; end
            end else if (b && a) m_pc = ba & ~32'h3;
            else if (b) begin m_red = ba & ~32'h3; m_drain = 1'b1; end
            else if (a && !f) m_pc = m_pc + 32'd4;
            else if (a) begin m_hi = memf(m_pc); m_hp = m_pc + 32'd4; m_hold = 1'b1; end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; imem_ack = 1'b0; imem_rdata = '0; rst = 1'b1;
        test_reset;
        test_zero_wait;
        test_wait_states;
        test_freeze_hold;
        test_branch_drain;
        test_branch_same_cycle;
        test_reset_mid_read;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
